ram8: RTL
=========

RAM8 -- requirements
Module: ram8

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1: when 1, reset zero-fills all eight words; when 0, contents are left untouched by reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wr_valid  input  1  write request.
REQ-005 wr_ready  output  1  write port can accept.
REQ-006 wr_addr  input  3  write word address.
REQ-007 wr_data  input  16  write data.
REQ-008 rd_valid  input  1  read request.
REQ-009 rd_ready  output  1  read port can accept.
REQ-010 rd_addr  input  3  read word address.
REQ-011 rd_data  output  16  registered read data.
REQ-012 rd_data_compl  output  16  bitwise complement of rd_data.
REQ-013 rd_data_valid  output  1  one-cycle pulse marking new rd_data.

Function
REQ-014 The block has two states, CLEAR and READY; there are no other states.
REQ-015 CLEAR: a 3-bit clear counter steps 0..7, one word per cycle, loading 16'h0000 into word[counter].
- wr_ready=0 and rd_ready=0 throughout CLEAR.
REQ-016 CLEAR -> READY occurs on the cycle after counter=7 is written, so CLEAR lasts exactly 8 cycles.
REQ-017 READY: wr_ready=1 and rd_ready=1 every cycle; READY has no exit except rst.
REQ-018 Write handshake: a write is accepted when wr_valid&&wr_ready; word[wr_addr] takes wr_data at that edge; all other words hold.
REQ-019 Read handshake: a read is accepted when rd_valid&&rd_ready.
- rd_data takes word[rd_addr] at that edge; rd_data_valid=1 for the following cycle only.
REQ-020 Read latency is exactly 1 cycle from acceptance to rd_data_valid.
- Back-to-back reads on consecutive cycles are allowed and give consecutive valid pulses.
REQ-021 rd_data holds its last value until the next accepted read.
REQ-022 rd_data_compl = ~rd_data at all times, including during and after reset.
REQ-023 When a read and a write target the same address on the same edge, the read returns the pre-write value.
- The new value is returned by any later read.
REQ-024 Simultaneous read and write to different addresses are both fully served in that cycle.
REQ-025 Requests presented while the matching ready is 0 are ignored; they have no side effect.
REQ-026 Address decode is exhaustive; all 8 addresses are valid and there is no out-of-range case.

Reset
REQ-027 While rst=1: state=CLEAR, clear counter=0, wr_ready=0, rd_ready=0, rd_data=16'h0000, rd_data_compl=16'hFFFF, rd_data_valid=0.
REQ-028 With CLEAR_ON_RESET=1, CLEAR runs after rst deasserts.
- Asserting rst mid-CLEAR restarts the counter at 0.
REQ-029 With CLEAR_ON_RESET=0, the first cycle after rst deasserts is READY and storage keeps its prior contents.
REQ-030 rst asserted during READY aborts any request on that edge; no write lands and no rd_data_valid follows.

Structure
REQ-031 Package ram_pkg holds WORD_W=16, ADDR_W=3, DEPTH=8 and the two-value state enum (CLEAR, READY).
REQ-032 Storage is eight instances of the existing reg16 sub-module.
- Each load is driven from the one-hot decode of the write/clear address.
- Each in is muxed between wr_data and zero.
REQ-033 The reg16 out_compl outputs are unused.
- rd_data_compl is generated from the registered rd_data.

Verification
REQ-034 Reset and clear: rst high 2 cycles then low -> ready=0 for exactly 8 cycles, then 1; read of every address returns 16'h0000 with rd_data_compl=16'hFFFF.
REQ-035 Write then read: write addr 5 = 16'hA5C3, then read addr 5 -> rd_data_valid one cycle after acceptance, rd_data=16'hA5C3, rd_data_compl=16'h5A3C; other seven words still 0.
REQ-036 Same-address collision: word 2 = 16'h1111; same-cycle write 16'h2222 and read of addr 2 -> read returns 16'h1111; the next read returns 16'h2222.
REQ-037 Back-to-back reads: reads of addr 0..7 on 8 consecutive cycles after writing word[i]=i*16'h0101 -> 8 consecutive valid pulses with the matching data, in order.
REQ-038 Reset mid-clear: rst at clear step 4 for 1 cycle -> CLEAR restarts and lasts a full 8 cycles from deassertion; a write attempted during CLEAR is dropped.
REQ-039 CLEAR_ON_RESET=0: write word 3 = 16'hBEEF, pulse rst -> ready=1 on the first cycle after rst; read addr 3 returns 16'hBEEF.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared sizes, state encoding and address decode for the eight-word RAM.
package ram_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] addr);
        return DEPTH'(1) << addr;
    endfunction

endpackage

// File: rtl/reg16.sv
// Sixteen-bit load-enabled storage register with a complemented copy of its value.
module reg16 (
    input  logic        clk,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic [15:0] out_compl
);

    // No reset: contents must survive reset when clearing is disabled.
    logic [15:0] val_q;

    always_ff @(posedge clk) begin
        if (load) begin
            val_q <= in;
        end
    end

    assign out       = val_q;
    assign out_compl = ~val_q;

endmodule

// File: rtl/ram8.sv
// Eight-word by sixteen-bit RAM with valid/ready write and read ports and an
// optional zero-fill sequence after reset.
module ram8
    import ram_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic [WORD_W-1:0] rd_data_compl,
    output logic              rd_data_valid,
    output state_t            dbg_state_o
);

    // Handshake: a request transfers on a rising edge where valid and ready
    // are both high; ready never depends on valid, and requests seen while
    // ready is low leave no trace.
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] rd_data_q;
    logic              rd_valid_q;

    logic              port_ready;
    logic              clearing;
    logic              wr_fire;
    logic              rd_fire;
    logic [ADDR_W-1:0] sel_addr;
    logic [DEPTH-1:0]  load_vec;
    logic [WORD_W-1:0] word_in;
    logic [WORD_W-1:0] word_out [DEPTH];
    logic [WORD_W-1:0] unused_compl [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Without zero-fill, CLEAR only survives the single cycle after reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            if (!CLEAR_ON_RESET || cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = READY;
            end
            if (CLEAR_ON_RESET) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Gated by rst so a request on a reset edge never lands.
    assign port_ready = !rst && (state_q == READY || !CLEAR_ON_RESET);
    assign clearing   = !rst && CLEAR_ON_RESET && (state_q == CLEAR);
    assign wr_fire    = wr_valid && port_ready;
    assign rd_fire    = rd_valid && port_ready;

    assign sel_addr = clearing ? cnt_q : wr_addr;
    assign load_vec = (clearing || wr_fire) ? onehot(sel_addr) : '0;
    assign word_in  = clearing ? '0 : wr_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        reg16 u_word (
            .clk      (clk),
            .load     (load_vec[i]),
            .in       (word_in),
            .out      (word_out[i]),
            .out_compl(unused_compl[i])
        );
    end

    // Storage is read before this edge's write lands, so a same-address
    // collision returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= word_out[rd_addr];
            end
        end
    end

    assign wr_ready      = port_ready;
    assign rd_ready      = port_ready;
    assign rd_data       = rd_data_q;
    assign rd_data_compl = ~rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign dbg_state_o   = state_q;

endmodule
